// File: rtl/weight_rom_sequencer.sv
// weight_rom_sequencer: hidden/output-layer weight ROM address sweep with back-pressure and latency-aligned valid
module weight_rom_sequencer #(
  parameter int N_IN = 400,
  parameter int N_HID = 20,
  parameter int OUT_BASE = 512
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iStall,
  input  logic       iAct_Ready,
  output logic [9:0] oAddr_ROM_0,
  output logic [8:0] oAddr_Hid,
  output logic       oWeight_Valid,
  output logic [8:0] oIdx,
  output logic       oBias,
  output logic       oLayer,
  output logic       oHid_Done,
  output logic       oDone,
  output logic       oBusy
);
  localparam logic [1:0] IDLE = 2'd0, HIDDEN = 2'd1, WAIT_ACT = 2'd2, OUTPUT = 2'd3;
  logic [1:0] state;
  logic [9:0] cnt;
  logic issue, last;
  always_comb begin
    issue = (state == HIDDEN || state == OUTPUT) && !iStall;
    last = cnt == (state == OUTPUT ? 10'(N_HID) : 10'(N_IN));
    oBusy = state != IDLE;
    oAddr_ROM_0 = state == OUTPUT ? 10'(OUT_BASE) + cnt : cnt;
    oAddr_Hid = state == OUTPUT ? 9'd0 : cnt[8:0];
  end
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      state <= IDLE;
      cnt <= '0;
      oWeight_Valid <= 1'b0;
      oIdx <= '0;
      oBias <= 1'b0;
      oLayer <= 1'b0;
      oHid_Done <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oWeight_Valid <= issue;
      oIdx <= cnt[8:0];
      oBias <= issue && last;
      oLayer <= state == OUTPUT;
      oHid_Done <= issue && last && state == HIDDEN;
      oDone <= issue && last && state == OUTPUT;
      if (state == IDLE && iStart) begin
        state <= HIDDEN;
        cnt <= '0;
      end else if (state == WAIT_ACT && iAct_Ready) begin
        state <= OUTPUT;
        cnt <= '0;
      end else if (issue) begin
        cnt <= last ? '0 : cnt + 10'd1;
        if (last) state <= state == HIDDEN ? WAIT_ACT : IDLE;
      end
    end
endmodule

// File: tb/tb_weight_rom_sequencer.sv
// tb_weight_rom_sequencer: scoreboard bench for the weight ROM sequencer
module tb_weight_rom_sequencer;
  localparam int NI = 400, NH = 20, OB = 512;
  typedef struct packed {
    logic layer;
    logic [8:0] idx;
    logic bias;
    logic hd;
    logic dn;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, act = 1'b0;
  logic [9:0] a0;
  logic [8:0] ah, idx;
  logic valid, bias, layer, hid_done, done, busy;
  logic s_start = 1'b0;
  logic [9:0] s_a0;
  logic [8:0] s_ah, s_idx;
  logic s_valid, s_bias, s_layer, s_hd, s_done, s_busy;
  int checks = 0, fails = 0, cyc = 0, s_n = 0;
  exp_t q[$];
  logic [9:0] pa0 = '0, s_pa0 = '0;
  logic [8:0] pah = '0;
  weight_rom_sequencer dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iStall(stall), .iAct_Ready(act),
    .oAddr_ROM_0(a0), .oAddr_Hid(ah), .oWeight_Valid(valid), .oIdx(idx), .oBias(bias),
    .oLayer(layer), .oHid_Done(hid_done), .oDone(done), .oBusy(busy)
  );
  weight_rom_sequencer #(.N_IN(3), .N_HID(2), .OUT_BASE(16)) u_small (
    .iClk(clk), .iRst_n(rst_n), .iStart(s_start), .iStall(1'b0), .iAct_Ready(1'b1),
    .oAddr_ROM_0(s_a0), .oAddr_Hid(s_ah), .oWeight_Valid(s_valid), .oIdx(s_idx), .oBias(s_bias),
    .oLayer(s_layer), .oHid_Done(s_hd), .oDone(s_done), .oBusy(s_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, act_v, exp_v, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void push_frame();
    for (int i = 0; i <= NI; i++) q.push_back('{1'b0, 9'(i), i == NI, i == NI, 1'b0});
    for (int j = 0; j <= NH; j++) q.push_back('{1'b1, 9'(j), j == NH, 1'b0, j == NH});
  endfunction
  // Scoreboard monitor: the ROM address must lead the matching valid by one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid got idx=%0d layer=%0d expected no valid", idx, layer);
        end else begin
          e = q.pop_front();
          chk("valid_word", {layer, idx, bias, hid_done, done, pa0, pah},
              {e, e.layer ? 10'(OB) + 10'(e.idx) : 10'(e.idx), e.layer ? 9'd0 : e.idx});
        end
      end else chk("strobes_without_valid", {bias, hid_done, done}, 3'b000);
      pa0 = a0;
      pah = ah;
    end else begin
      pa0 = '0;
      pah = '0;
    end
  end
  always @(negedge clk) begin
    int si;
    logic sl;
    if (rst_n) begin
      if (s_valid) begin
        sl = s_n >= 4;
        si = sl ? s_n - 4 : s_n;
        chk("small_word", {s_layer, s_idx, s_bias, s_done, s_pa0},
            {sl, 9'(si), si == (sl ? 2 : 3), s_n == 6, sl ? 10'(16 + si) : 10'(si)});
        s_n++;
      end
      s_pa0 = s_a0;
    end
  end
  // mode: 0 no stall, 1 stall on cycles 10-12 and the last hidden issue, 2 random stalls
  task automatic frame(input int mode, input int act_dly, input bit junk, input bit held);
    int start_c, t, issued, k;
    bit s, ls;
    start = 1'b1;
    start_c = cyc;
    push_frame();
    step();
    start = held;
    chk("busy_after_start", busy, 1'b1);
    issued = 0;
    ls = 0;
    while (issued <= NI) begin
      k = cyc - start_c;
      s = mode == 1 ? ((k >= 10 && k <= 12) || (issued == NI && !ls)) :
          mode == 2 ? ($urandom_range(99) < 25) : 1'b0;
      if (mode == 1 && issued == NI && s) ls = 1;
      stall = s;
      if (junk) begin
        start = 1'($urandom_range(1));
        act = 1'($urandom_range(1));
      end
      if (!s) issued++;
      step();
    end
    act = 1'b0;
    start = held;
    chk("hid_done_pulse", hid_done, 1'b1);
    if (mode < 2) chk("hid_done_cycle", 64'(cyc - start_c), mode == 1 ? 64'(NI + 6) : 64'(NI + 2));
    repeat (act_dly) begin
      stall = 1'($urandom_range(1));
      start = junk ? 1'($urandom_range(1)) : held;
      step();
      chk("waiting_busy", {busy, valid}, 2'b10);
    end
    stall = 1'b0;
    start = held;
    act = 1'b1;
    t = cyc;
    step();
    act = 1'b0;
    issued = 0;
    while (issued <= NH) begin
      s = mode == 2 ? ($urandom_range(99) < 25) : 1'b0;
      stall = s;
      if (junk) begin
        start = 1'($urandom_range(1));
        act = 1'($urandom_range(1));
      end
      if (!s) issued++;
      step();
    end
    stall = 1'b0;
    act = 1'b0;
    start = held;
    chk("done_pulse", done, 1'b1);
    chk("busy_low_in_done", busy, 1'b0);
    if (mode < 2) chk("done_cycle", 64'(cyc - t), 64'(NH + 2));
  endtask
  task automatic idle(input int n);
    repeat (n) step();
    chk("idle_busy", busy, 1'b0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int issued;
    step();
    step();
    chk("reset_outputs", {a0, ah, valid, idx, bias, layer, hid_done, done, busy}, 64'd0);
    rst_n = 1'b1;
    step();
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    repeat (20) step();
    chk("small_valid_count", 64'(s_n), 64'd7);
    frame(0, 5, 0, 0);
    idle(3);
    frame(1, 5, 0, 0);
    idle(3);
    frame(0, 5, 1, 0);
    idle(3);
    start = 1'b1;
    push_frame();
    step();
    start = 1'b0;
    issued = 0;
    while (issued < 200) begin
      issued++;
      step();
    end
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("reset_mid_sweep", {a0, ah, valid, idx, bias, layer, hid_done, done, busy}, 64'd0);
    repeat (3) begin
      step();
      chk("reset_held", {a0, ah, valid, idx, bias, layer, hid_done, done, busy}, 64'd0);
    end
    rst_n = 1'b1;
    repeat (3) step();
    chk("after_reset_quiet", {valid, busy}, 2'b00);
    frame(0, 5, 0, 0);
    idle(3);
    frame(2, $urandom_range(10), 0, 1);
    frame(2, $urandom_range(10), 0, 0);
    idle(3);
    frame(2, $urandom_range(10), 1, 0);
    idle(5);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
